mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  RV32I memory-access (MM) stage, directly upstream of the MM/WB pipeline register.
//  - Non-memory instructions: passes the EX result through to mm_we/mm_wa/mm_wn.
//  - Loads/stores: runs a multi-cycle byte-serial access over an 8-bit memory port.
//  - Holds the pipeline via stall_req until the access completes.
//  - Loads are assembled little-endian, sign/zero-extended, then presented for writeback.
// PARAMETERS
//  ADDR_W   32   width of mem_addr; low ADDR_W bits of (base+offset) driven, upper bits dropped
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       reset, synchronous, active-high
//  ex_we      in   1       instruction writes rd
//  ex_wa      in   5       rd index
//  ex_wn      in   32      ALU result; byte address when ex_memen=1
//  ex_memen   in   1       instruction is load/store
//  ex_memwr   in   1       1=store, 0=load (valid when ex_memen)
//  ex_memop   in   3       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_sdata   in   32      store data (rs2)
//  mm_we      out  1       to MM/WB: write enable
//  mm_wa      out  5       to MM/WB: rd index
//  mm_wn      out  32      to MM/WB: writeback value
//  stall_req  out  1       freeze IF..EX/MM registers and MM/WB capture this cycle
//  mem_req    out  1       byte request valid
//  mem_rw     out  1       1=write byte, 0=read byte
//  mem_addr   out  ADDR_W  byte address
//  mem_wdata  out  8       store byte
//  mem_ack    in   1       request accepted; for reads mem_rdata valid same cycle
//  mem_rdata  in   8       read byte
// BEHAVIOUR
//  - Reset:
//    - rst=1 at posedge -> state IDLE; cnt, base, nbytes, rbuf cleared.
//    - While rst=1, all outputs forced 0; a pending access is abandoned.
//  - States: IDLE, ACCESS, DONE (2-bit reg). cnt 2-bit byte index; nbytes 1/2/4 from ex_memop[1:0].
//  - IDLE, ex_memen=0:
//    - mm_* = ex_* combinationally; stall_req=0; mem_req=0.
//  - IDLE, ex_memen=1:
//    - stall_req=1, mm_we=0.
//    - Latch base=ex_wn, op, rw, sdata, we, wa; cnt<=0; rbuf<=0; next ACCESS.
//  - ACCESS:
//    - mem_req=1, stall_req=1, mm_we=0.
//    - mem_rw=latched rw; mem_addr=base+cnt (wraps mod 2^ADDR_W); mem_wdata=sdata[8*cnt+:8].
//    - Request and address held stable until mem_ack.
//    - On ack: read -> rbuf[8*cnt+:8]<=mem_rdata.
//    - On ack: cnt==nbytes-1 -> DONE, else cnt<=cnt+1.
//  - DONE:
//    - stall_req=0, mem_req=0; mm_we=latched we & ~rw; mm_wa=latched wa.
//    - Load mm_wn: B -> sext(rbuf[7:0]), H -> sext(rbuf[15:0]), W -> rbuf, BU/HU -> zext.
//    - Store mm_wn: 0.
//    - Next state IDLE unconditionally; pipeline advances this cycle, so the same op is never re-issued.
//  - Upstream holds ex_* stable while stall_req=1; inputs are ignored in ACCESS/DONE.
//  - Misaligned addresses are legal (byte-serial); reserved ex_memop values (011, 11x) are treated as W.
//  - Latency: n-byte access with mem_ack tied 1 -> stall_req high n+1 cycles, result in cycle n+2.
//  - mem_ack outside ACCESS is ignored.
//  - Store with ex_we=1 (malformed): no register write, mm_we=0.
// TESTING
//  - ALU op ex_we=1,wa=5,wn=0x1234, memen=0 -> same cycle mm_we=1,wa=5,wn=0x1234, stall_req=0.
//  - LW @0x100, ack always 1, mem returns 78,56,34,12 -> addrs 0x100..0x103;
//    stall_req 5 cycles; DONE mm_wn=0x12345678.
//  - LB @0x3 rdata 0x80 -> mm_wn=0xFFFFFF80; LBU -> 0x00000080; LH 0x8001 -> 0xFFFF8001.
//  - SH @0x201 sdata=0xAABBCCDD, ack delayed 3 cycles per byte -> writes CC@0x201, DD@0x200?
//    No: DD@0x201 then CC@0x202; req/addr stable while waiting; DONE mm_we=0.
//  - LW, rst asserted after 2 acks -> next cycle mem_req=0, stall_req=0, state IDLE;
//    new LW after reset starts at cnt 0.
//  - LW base=0xFFFFFFFE (ADDR_W=32) -> addrs FFFFFFFE, FFFFFFFF, 0, 1 (wrap).

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of a 5-stage RV32I pipeline. It sits directly in front
//   of the MM/WB pipeline register.
//   - Non-memory instructions: the EX result passes straight through, with no
//     register in the path.
//   - Loads and stores: the access runs one byte at a time over an 8-bit memory
//     port. stall_req holds the rest of the pipeline until the result is ready.
//   - Load bytes are assembled little-endian and then sign- or zero-extended.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   ex_we/ex_wa/ex_wn         EX result: rd write enable, rd index, ALU value
//                             (ex_wn is the byte address for loads and stores)
//   ex_memen/ex_memwr         load/store instruction; 1 = store
//   ex_memop                  funct3 (B/H/W/BU/HU)
//   ex_sdata                  store data (rs2)
//   mm_we/mm_wa/mm_wn         writeback triple presented to MM/WB
//   stall_req                 freeze upstream registers and MM/WB this cycle
//   mem_req/mem_rw/mem_addr/mem_wdata   byte request to memory
//   mem_ack/mem_rdata         request accepted; read byte is valid with ack
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_we,
    input  logic [4:0]        ex_wa,
    input  logic [31:0]       ex_wn,
    input  logic              ex_memen,
    input  logic              ex_memwr,
    input  logic [2:0]        ex_memop,
    input  logic [31:0]       ex_sdata,
    output logic              mm_we,
    output logic [4:0]        mm_wa,
    output logic [31:0]       mm_wn,
    output logic              stall_req,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  op_q, op_d;
    logic        rw_q, rw_d;
    logic [31:0] sdata_q, sdata_d;
    logic        we_q, we_d;
    logic [4:0]  wa_q, wa_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic [31:0] addr_full;
    logic        last_byte;

    // Extend the assembled load bytes according to funct3. Any size encoding
    // other than B (x00) or H (x01) is a full word, so no extension applies.
    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] rb);
        logic [31:0] r;
        case (op[1:0])
            2'b00:   r = op[2] ? {24'd0, rb[7:0]}  : {{24{rb[7]}}, rb[7:0]};
            2'b01:   r = op[2] ? {16'd0, rb[15:0]} : {{16{rb[15]}}, rb[15:0]};
            default: r = rb;
        endcase
        return r;
    endfunction

    // The byte address wraps modulo 2^32. Only the low ADDR_W bits are driven.
    assign addr_full = base_q + {30'd0, cnt_q};

    // This is the final byte of the access: 1, 2 or 4 bytes, chosen by funct3[1:0].
    always_comb begin
        case (op_q[1:0])
            2'b00:   last_byte = (cnt_q == 2'd0);
            2'b01:   last_byte = (cnt_q == 2'd1);
            default: last_byte = (cnt_q == 2'd3);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            base_q  <= 32'd0;
            op_q    <= 3'd0;
            rw_q    <= 1'b0;
            sdata_q <= 32'd0;
            we_q    <= 1'b0;
            wa_q    <= 5'd0;
            rbuf_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            op_q    <= op_d;
            rw_q    <= rw_d;
            sdata_q <= sdata_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            rbuf_q  <= rbuf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        op_d      = op_q;
        rw_d      = rw_q;
        sdata_d   = sdata_q;
        we_d      = we_q;
        wa_d      = wa_q;
        rbuf_d    = rbuf_q;

        mm_we     = 1'b0;
        mm_wa     = 5'd0;
        mm_wn     = 32'd0;
        stall_req = 1'b0;
        mem_req   = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'd0;

        case (state_q)
            IDLE: begin
                if (ex_memen) begin
                    stall_req = 1'b1;
                    base_d    = ex_wn;
                    op_d      = ex_memop;
                    rw_d      = ex_memwr;
                    sdata_d   = ex_sdata;
                    we_d      = ex_we;
                    wa_d      = ex_wa;
                    cnt_d     = 2'd0;
                    rbuf_d    = 32'd0;
                    state_d   = ACCESS;
                end else begin
                    mm_we = ex_we;
                    mm_wa = ex_wa;
                    mm_wn = ex_wn;
                end
            end
            ACCESS: begin
                stall_req = 1'b1;
                mem_req   = 1'b1;
                mem_rw    = rw_q;
                mem_addr  = addr_full[ADDR_W-1:0];
                mem_wdata = sdata_q[{cnt_q, 3'b000} +: 8];
                if (mem_ack) begin
                    if (!rw_q)
                        rbuf_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                    if (last_byte)
                        state_d = DONE;
                    else
                        cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                // A store never writes rd, even if ex_we was set with it.
                mm_we   = we_q & ~rw_q;
                mm_wa   = wa_q;
                mm_wn   = rw_q ? 32'd0 : load_ext(op_q, rbuf_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // While reset is held, every output is quiet, including the passthrough path.
        if (rst) begin
            mm_we     = 1'b0;
            mm_wa     = 5'd0;
            mm_wn     = 32'd0;
            stall_req = 1'b0;
            mem_req   = 1'b0;
            mem_rw    = 1'b0;
            mem_addr  = '0;
            mem_wdata = 8'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_we;
    logic [4:0]  ex_wa;
    logic [31:0] ex_wn;
    logic        ex_memen;
    logic        ex_memwr;
    logic [2:0]  ex_memop;
    logic [31:0] ex_sdata;
    logic        mm_we;
    logic [4:0]  mm_wa;
    logic [31:0] mm_wn;
    logic        stall_req;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Byte-addressed memory model; unknown locations get a random byte on first read.
    logic [7:0] mem_model [logic [31:0]];

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_we(ex_we), .ex_wa(ex_wa), .ex_wn(ex_wn),
        .ex_memen(ex_memen), .ex_memwr(ex_memwr), .ex_memop(ex_memop), .ex_sdata(ex_sdata),
        .mm_we(mm_we), .mm_wa(mm_wa), .mm_wn(mm_wn), .stall_req(stall_req),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
        return mem_model[a];
    endfunction

    task automatic alu_op(input logic we, input logic [4:0] wa, input logic [31:0] wn);
        @(negedge clk);
        ex_memen = 1'b0; ex_we = we; ex_wa = wa; ex_wn = wn; mem_ack = 1'b0;
        #1;
        chk("alu_we", mm_we, we);
        chk("alu_wa", mm_wa, wa);
        chk("alu_wn", mm_wn, wn);
        chk("alu_stall", stall_req, 0);
        chk("alu_req", mem_req, 0);
    endtask

    // One load/store from issue to the writeback cycle. dly < 0 picks a random
    // ack delay (0..3 idle cycles) per byte.
    task automatic run_access(input logic [2:0] op, input logic wr, input logic [31:0] addr,
                              input logic [31:0] sd, input logic we, input logic [4:0] wa,
                              input int dly);
        int n, d, dsum, stalls;
        logic [31:0] expv, a;
        n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        expv = 32'd0;
        if (!wr) begin
            for (int i = 0; i < n; i++)
                expv = expv | (32'(mem_rd(addr + 32'(i))) << (8 * i));
            if (!op[2] && n < 4 && ((expv >> (8 * n - 1)) & 32'd1) == 32'd1)
                expv = expv | ~((32'd1 << (8 * n)) - 32'd1);
        end
        dsum = 0;
        @(negedge clk);
        ex_memen = 1'b1; ex_memwr = wr; ex_memop = op; ex_wn = addr;
        ex_sdata = sd; ex_we = we; ex_wa = wa; mem_ack = 1'b0;
        #1;
        chk("issue_stall", stall_req, 1);
        chk("issue_mmwe", mm_we, 0);
        chk("issue_req", mem_req, 0);
        stalls = int'(stall_req);
        for (int i = 0; i < n; i++) begin
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            dsum += d;
            a = addr + 32'(i);
            for (int w = 0; w <= d; w++) begin
                @(negedge clk);
                mem_ack = 1'b0;
                mem_rdata = 8'($urandom);
                #1;
                chk("acc_req", mem_req, 1);
                chk("acc_stall", stall_req, 1);
                chk("acc_mmwe", mm_we, 0);
                chk("acc_addr", mem_addr, a);
                chk("acc_rw", mem_rw, wr);
                if (wr) chk("acc_wdata", mem_wdata, (sd >> (8 * i)) & 32'hFF);
                stalls += int'(stall_req);
                if (w == d) begin
                    mem_ack = 1'b1;
                    if (wr) mem_model[a] = 8'(sd >> (8 * i));
                    else    mem_rdata = mem_rd(a);
                end
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("done_stall", stall_req, 0);
        chk("done_req", mem_req, 0);
        chk("done_mmwe", mm_we, we & ~wr);
        chk("done_mmwa", mm_wa, wa);
        chk("done_mmwn", mm_wn, wr ? 32'd0 : expv);
        stalls += int'(stall_req);
        chk("stall_cycles", stalls, 1 + n + dsum);
    endtask

    initial begin
        rst = 1'b1; ex_we = 1'b1; ex_wa = 5'd7; ex_wn = 32'hDEADBEEF; ex_memen = 1'b0;
        ex_memwr = 1'b0; ex_memop = 3'b010; ex_sdata = 32'd0; mem_ack = 1'b1; mem_rdata = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_mmwe", mm_we, 0);
        chk("rst_mmwn", mm_wn, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_req", mem_req, 0);
        rst = 1'b0;

        // ALU passthrough
        alu_op(1'b1, 5'd5, 32'h1234);
        alu_op(1'b0, 5'd31, 32'hCAFEF00D);

        // LW @0x100, ack tied high
        mem_model[32'h100] = 8'h78; mem_model[32'h101] = 8'h56;
        mem_model[32'h102] = 8'h34; mem_model[32'h103] = 8'h12;
        run_access(3'b010, 1'b0, 32'h100, 32'd0, 1'b1, 5'd3, 0);
        chk("lw_value", mm_wn, 32'h12345678);

        // Sign and zero extension
        mem_model[32'h3] = 8'h80;
        run_access(3'b000, 1'b0, 32'h3, 32'd0, 1'b1, 5'd4, 0);
        run_access(3'b100, 1'b0, 32'h3, 32'd0, 1'b1, 5'd4, 1);
        mem_model[32'h10] = 8'h01; mem_model[32'h11] = 8'h80;
        run_access(3'b001, 1'b0, 32'h10, 32'd0, 1'b1, 5'd6, 0);
        chk("lh_value", mm_wn, 32'hFFFF8001);
        run_access(3'b101, 1'b0, 32'h10, 32'd0, 1'b1, 5'd6, 2);

        // Misaligned SH with delayed ack; ex_we=1 must still give no write
        run_access(3'b001, 1'b1, 32'h201, 32'hAABBCCDD, 1'b1, 5'd9, 3);
        run_access(3'b101, 1'b0, 32'h201, 32'd0, 1'b1, 5'd9, 0);
        chk("sh_readback", mm_wn, 32'h0000CCDD);

        // Reset in the middle of a load
        @(negedge clk);
        ex_memen = 1'b1; ex_memwr = 1'b0; ex_memop = 3'b010; ex_wn = 32'h40;
        ex_we = 1'b1; ex_wa = 5'd2; mem_ack = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'h11; #1;
        chk("rmid_addr0", mem_addr, 32'h40);
        @(negedge clk);
        mem_rdata = 8'h22; #1;
        chk("rmid_addr1", mem_addr, 32'h41);
        @(negedge clk);
        #1;
        chk("rmid_addr2", mem_addr, 32'h42);
        rst = 1'b1; #1;
        chk("rmid_req", mem_req, 0);
        chk("rmid_stall", stall_req, 0);
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0; ex_memen = 1'b0; ex_we = 1'b0; #1;
        chk("rpost_stall", stall_req, 0);
        chk("rpost_req", mem_req, 0);
        run_access(3'b010, 1'b0, 32'h40, 32'd0, 1'b1, 5'd2, 0);

        // Address wrap
        run_access(3'b010, 1'b0, 32'hFFFFFFFE, 32'd0, 1'b1, 5'd8, 0);

        // Reserved funct3 values behave as word
        run_access(3'b011, 1'b0, 32'h300, 32'd0, 1'b1, 5'd1, 0);
        run_access(3'b111, 1'b1, 32'h304, 32'h01020304, 1'b0, 5'd1, 0);

        // Randomized mix; stores feed later loads through the memory model
        for (int k = 0; k < 40; k++) begin
            logic [2:0] op;
            logic [31:0] ad;
            op = 3'($urandom_range(0, 7));
            ad = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                             : 32'($urandom_range(32'h400, 32'h40F));
            if ($urandom_range(0, 4) == 0)
                alu_op(1'($urandom), 5'($urandom), $urandom);
            else
                run_access(op, 1'($urandom), ad, $urandom, 1'($urandom), 5'($urandom), -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
